// File: rtl/sc_score_keeper_if.sv
// sc_score_keeper_if: match event bus from the match serializer into the score keeper.
// Signals: match_en (valid match), match_dt (16-bit absolute timing error),
// miss (note expired unmatched), star_active (only when SC_STAR_POWER_EN is defined).
// master drives the bus, slave consumes it.
interface sc_score_keeper_if;
  logic        match_en;
  logic [15:0] match_dt;
  logic        miss;
`ifdef SC_STAR_POWER_EN
  logic        star_active;
  modport master(output match_en, match_dt, miss, star_active);
  modport slave(input match_en, match_dt, miss, star_active);
`else
  modport master(output match_en, match_dt, miss);
  modport slave(input match_en, match_dt, miss);
`endif
endinterface

// File: rtl/sc_score_keeper.sv
// sc_score_keeper: grades serialized matches by timing error and accumulates score/combo/multiplier.
// Ports: clk, rst_n (async active-low), clear (sync, same effect as reset),
// in_if (slave: match_en, match_dt, miss[, star_active]),
// score[23:0], combo[9:0], max_combo[9:0], multiplier[2:0], grade[1:0], grade_valid.
// Optional: define SC_STAR_POWER_EN to add star_active, which doubles hit points.
// Pipeline: stage 1 registers the grade, stage 2 accumulates.
module sc_score_keeper #(
  parameter logic [15:0] PERFECT_DT = 16'd20,
  parameter logic [15:0] GOOD_DT    = 16'd50,
  parameter logic [15:0] OK_DT      = 16'd100,
  parameter int unsigned PTS_PERFECT = 100,
  parameter int unsigned PTS_GOOD    = 50,
  parameter int unsigned PTS_OK      = 20,
  parameter int unsigned COMBO_STEP  = 10,
  parameter int unsigned MAX_MULT    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  sc_score_keeper_if.slave    in_if,
  output logic [23:0]         score,
  output logic [9:0]          combo,
  output logic [9:0]          max_combo,
  output logic [2:0]          multiplier,
  output logic [1:0]          grade,
  output logic                grade_valid
);
  function automatic logic [2:0] mult_of(input logic [9:0] c);
    int unsigned m;
    m = 1 + 32'(c) / COMBO_STEP;
    return 3'(m > MAX_MULT ? MAX_MULT : m);
  endfunction
  logic        ev_q, ev_d, miss1_q, miss1_d, star_q, star_d;
  logic [1:0]  grade1_q, grade1_d, g, grade_q, grade_d;
  logic [23:0] score_q, score_d;
  logic [9:0]  combo_q, combo_d, max_q, max_d, base_combo;
  logic [2:0]  mult_q, mult_d, mult_eff;
  logic        gv_q, gv_d, hit;
  logic [6:0]  base_pts;
  logic [10:0] pts_raw, pts;
  logic [24:0] sum;
  always_comb begin
    g = in_if.match_dt <= PERFECT_DT ? 2'd3 :
        in_if.match_dt <= GOOD_DT    ? 2'd2 :
        in_if.match_dt <= OK_DT      ? 2'd1 : 2'd0;
    ev_d     = !clear && (in_if.match_en || in_if.miss);
    // A miss pulse, or a match graded MISS, both break the combo before any hit in the event.
    miss1_d  = !clear && (in_if.miss || (in_if.match_en && g == 2'd0));
    grade1_d = (clear || !in_if.match_en) ? 2'd0 : g;
`ifdef SC_STAR_POWER_EN
    star_d   = !clear && in_if.star_active;
`else
    star_d   = 1'b0;
`endif
    // Points use the multiplier implied by the combo before this hit, so back-to-back
    // hits are not penalised by the one-cycle lag of the multiplier output register.
    base_combo = miss1_q ? 10'd0 : combo_q;
    hit        = ev_q && grade1_q != 2'd0;
    mult_eff   = mult_of(base_combo);
    base_pts   = grade1_q == 2'd3 ? 7'(PTS_PERFECT) :
                 grade1_q == 2'd2 ? 7'(PTS_GOOD) : 7'(PTS_OK);
    pts_raw    = 11'(base_pts) * 11'(mult_eff);
    pts        = star_q ? pts_raw << 1 : pts_raw;
    sum        = {1'b0, score_q} + 25'(pts);
    score_d = clear ? 24'd0 : hit ? (sum[24] ? 24'hFFFFFF : sum[23:0]) : score_q;
    combo_d = clear ? 10'd0 :
              hit   ? (base_combo == 10'd1023 ? 10'd1023 : base_combo + 10'd1) :
              ev_q  ? 10'd0 : combo_q;
    max_d   = clear ? 10'd0 : combo_d > max_q ? combo_d : max_q;
    mult_d  = clear ? 3'd1 : mult_of(combo_q);
    grade_d = clear ? 2'd0 : ev_q ? grade1_q : grade_q;
    gv_d    = !clear && ev_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ev_q     <= 1'b0;
      miss1_q  <= 1'b0;
      grade1_q <= 2'd0;
      star_q   <= 1'b0;
      score_q  <= 24'd0;
      combo_q  <= 10'd0;
      max_q    <= 10'd0;
      mult_q   <= 3'd1;
      grade_q  <= 2'd0;
      gv_q     <= 1'b0;
    end else begin
      ev_q     <= ev_d;
      miss1_q  <= miss1_d;
      grade1_q <= grade1_d;
      star_q   <= star_d;
      score_q  <= score_d;
      combo_q  <= combo_d;
      max_q    <= max_d;
      mult_q   <= mult_d;
      grade_q  <= grade_d;
      gv_q     <= gv_d;
    end
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = max_q;
  assign multiplier  = mult_q;
  assign grade       = grade_q;
  assign grade_valid = gv_q;
endmodule

// File: tb/tb_sc_score_keeper.sv
// tb_sc_score_keeper: table, hand sequences and random events checked against a behavioural model.
module tb_sc_score_keeper;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  always #5 clk = ~clk;
  sc_score_keeper_if bus();
  logic [23:0] score;
  logic [9:0]  combo, max_combo;
  logic [2:0]  multiplier;
  logic [1:0]  grade;
  logic        grade_valid;
  sc_score_keeper dut(.clk(clk), .rst_n(rst_n), .clear(clear), .in_if(bus.slave),
    .score(score), .combo(combo), .max_combo(max_combo), .multiplier(multiplier),
    .grade(grade), .grade_valid(grade_valid));
  int vectors = 0, miscompares = 0;
  typedef struct { int unsigned score, combo, maxc, grade; bit gv; } st_t;
  typedef struct { bit en; int unsigned dt; bit ms; int unsigned g; } vec_t;
  st_t m, pend;
  int unsigned last_combo;
  vec_t tab[8];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int unsigned grade_of(input int unsigned dt);
    return dt <= 20 ? 3 : dt <= 50 ? 2 : dt <= 100 ? 1 : 0;
  endfunction
  function automatic int unsigned mult_of(input int unsigned c);
    return (1 + c / 10 > 4) ? 4 : 1 + c / 10;
  endfunction
  function automatic int unsigned pts_of(input int unsigned g);
    int unsigned t[4];
    t = '{0, 20, 50, 100};
    return t[g];
  endfunction
  task automatic model_event(input bit en, input int unsigned dt, input bit ms);
    int unsigned g, s;
    g = grade_of(dt);
    if (ms) m.combo = 0;
    if (en && g != 0) begin
      s = m.score + pts_of(g) * mult_of(m.combo);
      m.score = s > 'hFFFFFF ? 'hFFFFFF : s;
      m.combo = m.combo == 1023 ? 1023 : m.combo + 1;
    end else if (en) m.combo = 0;
    if (m.combo > m.maxc) m.maxc = m.combo;
    m.grade = en ? g : 0;
  endtask
  task automatic model_reset();
    m = '{default: 0};
    pend = m;
    last_combo = 0;
  endtask
  task automatic step(input bit en, input int unsigned dt, input bit ms, input bit clr);
    st_t e;
    int unsigned em;
    bus.match_en = en;
    bus.match_dt = 16'(dt > 65535 ? 65535 : dt);
    bus.miss = ms;
    clear = clr;
    if (clr) begin
      model_reset();
      e = m;
      em = 1;
    end else begin
      e = pend;
      em = mult_of(last_combo);
      if (en || ms) model_event(en, dt, ms);
      pend = m;
      pend.gv = en || ms;
      last_combo = e.combo;
    end
    @(posedge clk);
    #1;
    check("score", score, e.score);
    check("combo", combo, e.combo);
    check("max_combo", max_combo, e.maxc);
    check("grade", grade, e.grade);
    check("grade_valid", grade_valid, e.gv);
    check("multiplier", multiplier, em);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask
  initial begin
`ifdef SC_STAR_POWER_EN
    bus.star_active = 1'b0;
`endif
    bus.match_en = 0; bus.match_dt = 0; bus.miss = 0;
    model_reset();
    tab[0] = '{1, 20, 0, 3};
    tab[1] = '{1, 21, 0, 2};
    tab[2] = '{1, 50, 0, 2};
    tab[3] = '{1, 100, 0, 1};
    tab[4] = '{1, 101, 0, 0};
    tab[5] = '{0, 0, 1, 0};
    tab[6] = '{1, 0, 0, 3};
    tab[7] = '{1, 65535, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_score", score, 0);
    check("rst_mult", multiplier, 1);
    check("rst_gv", grade_valid, 0);
    rst_n = 1'b1;
    // First hit: visible two cycles later, multiplier still 1.
    step(1, 15, 0, 0);
    idle(1);
    check("first_grade", grade, 3);
    check("first_gv", grade_valid, 1);
    check("first_score", score, 100);
    check("first_combo", combo, 1);
    check("first_mult", multiplier, 1);
    // Grade thresholds, back to back.
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(tab[i].en, tab[i].dt, tab[i].ms, 0);
      if (i > 0) check("tab_grade", grade, tab[i-1].g);
    end
    idle(1);
    check("tab_grade_last", grade, tab[7].g);
    idle(1);
    check("tab_score", score, 320);
    check("tab_combo", combo, 0);
    // 25 perfect hits: multiplier steps 1 -> 2 -> 3.
    step(0, 0, 0, 1);
    for (int i = 0; i < 25; i++) step(1, 5, 0, 0);
    idle(2);
    check("run_combo", combo, 25);
    check("run_max", max_combo, 25);
    check("run_mult", multiplier, 3);
    check("run_score", score, 4500);
    // Miss breaks combo but max is kept.
    step(0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 30, 0, 0);
    step(0, 0, 1, 0);
    idle(2);
    check("miss_mult", multiplier, 1);
    for (int i = 0; i < 3; i++) step(1, 30, 0, 0);
    idle(2);
    check("miss_combo", combo, 3);
    check("miss_max", max_combo, 12);
    // Simultaneous miss and match: miss applied first, single pulse.
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 10, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    check("dual_combo", combo, 1);
    check("dual_grade", grade, 3);
    check("dual_gv", grade_valid, 1);
    step(0, 0, 0, 0);
    check("dual_gv_once", grade_valid, 0);
    // Random events with occasional clear.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0 ? $urandom_range(101, 65535) : $urandom_range(0, 110),
           $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
    // Saturation at MAX_MULT, then async reset mid-stream.
    step(0, 0, 0, 1);
    for (int i = 0; i < 42100; i++) step(1, 0, 0, 0);
    idle(2);
    check("sat_score", score, 24'hFFFFFF);
    check("sat_combo", combo, 1023);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("arst_score", score, 0);
    check("arst_combo", combo, 0);
    check("arst_max", max_combo, 0);
    check("arst_mult", multiplier, 1);
    check("arst_grade", grade, 0);
    check("arst_gv", grade_valid, 0);
    bus.match_en = 0; bus.miss = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sc_score_keeper.md
Name: sc_score_keeper

Overview:
- Scoring stage directly downstream of the match serializer. Consumes one serialized match per cycle (match_en, match_dt) plus the note-expiry miss pulse.
- Grades each match by timing error and maintains score, combo, max combo and multiplier for the HUD and seven-segment display logic.
- Two-stage pipeline: grade, then accumulate.

Parameters:
- PERFECT_DT, 16'd20: dt <= this grades PERFECT (song_time units).
- GOOD_DT, 16'd50: dt <= this grades GOOD.
- OK_DT, 16'd100: dt <= this grades OK; larger dt grades MISS.
- PTS_PERFECT, 100: base points for PERFECT.
- PTS_GOOD, 50: base points for GOOD.
- PTS_OK, 20: base points for OK.
- COMBO_STEP, 10: combo hits per multiplier increment.
- MAX_MULT, 4: multiplier ceiling.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear at song start; same effect as reset
- match_en  in  1  valid match this cycle
- match_dt  in  16  absolute timing error of the match
- miss  in  1  one-cycle pulse: a note scrolled past unmatched
- score  out  24  accumulated score
- combo  out  10  current consecutive-hit count
- max_combo  out  10  highest combo reached since clear
- multiplier  out  3  current multiplier, 1..MAX_MULT
- grade  out  2  last grade: 0 MISS, 1 OK, 2 GOOD, 3 PERFECT
- grade_valid  out  1  one-cycle pulse when grade updates

Behaviour:
- Reset: rst_n low asynchronously sets score=0, combo=0, max_combo=0, multiplier=1, grade=0, grade_valid=0, and all pipeline registers to 0. clear does the same synchronously and has priority over all inputs in that cycle.
- Stage 1, registered on the cycle match_en or miss is sampled:
  - Grade is the first true of: dt<=PERFECT_DT -> PERFECT; dt<=GOOD_DT -> GOOD; dt<=OK_DT -> OK; else MISS.
  - A miss pulse with no match_en grades MISS.
  - match_en and miss in the same cycle: register both. Stage 2 applies the miss first, then the match.
- Stage 2 (accumulate):
  - A hit (grade != MISS) adds base_points*multiplier to score, where multiplier is the value before this hit. It then increments combo.
  - A MISS zeroes combo. score is unchanged.
  - Score saturates at 24'hFFFFFF. combo saturates at 1023.
  - multiplier = min(1 + combo/COMBO_STEP, MAX_MULT), recomputed registered from the new combo. It is visible the cycle after combo updates.
  - max_combo updates whenever the new combo exceeds it, in the same cycle as combo.
- Latency: match_en at cycle N -> score/combo/grade/grade_valid updated at N+2. multiplier updates at N+3.
- grade_valid pulses once per input event. A simultaneous miss+match produces one pulse with grade = the match's grade.
- Throughput: one event per cycle, back-to-back, no stall. The upstream block has no backpressure.
- clear mid-pipeline discards any in-flight events.

Optional Feature:
- SC_STAR_POWER_EN:
  - Defined: adds input star_active (1 bit), sampled in stage 1 alongside the event. When set, hit points are doubled (base*multiplier*2), with the same saturation. A MISS has no effect on star state.
  - Undefined: port absent; points are base*multiplier.

Test Plan:
- Reset then match_en=1, dt=15 -> at +2 cycles: grade=3, grade_valid=1, score=100, combo=1. multiplier stays 1.
- dt values 20, 21, 50, 100, 101 in consecutive cycles -> grades 3, 2, 2, 1, 0. combo ends 0. score=100+50+50+20=220.
- 25 consecutive PERFECT hits -> combo=25, max_combo=25, multiplier=3. score=10*100+10*200+5*300=4500.
- After 12 hits, one miss pulse, then 3 hits -> combo=3, max_combo=12. multiplier=1 after the miss.
- match_en (dt=0) and miss in the same cycle with combo=5 -> combo=1, one grade_valid pulse, grade=3.
- Score preloaded near saturation via long PERFECT run at MAX_MULT -> score holds 24'hFFFFFF, no wrap. Assert rst_n low mid-stream -> all outputs reset immediately, no pulse after release.
